usb_bus_master: RTL and testbench

- Initiator for the CW305 parallel USB target bus (22-bit address, 8-bit data, active-low RD/WR/CE).
- Turns a valid/ready command stream (single-byte read or write) into bus cycles with programmable setup/strobe/hold timing.
- Returns read data on a response port.
- Used as the SAM3U-side bus model in FPGA self-test/loopback builds and in simulation, driving the existing target-side register block.

---
 rtl/usb_bus_pkg.sv | 26 ++
 rtl/usb_bus_master_if.sv | 41 ++++
 rtl/usb_bus_master.sv | 190 +++++++++++++++++++
 tb/tb_usb_bus_master.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/usb_bus_pkg.sv
// Shared state encoding, default bus timing and a small helper for the USB bus master.
// Latency: none, this file holds declarations only.
// Backpressure: none, this file holds declarations only.
package usb_bus_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SETUP  = 3'd1,
        ST_STROBE = 3'd2,
        ST_HOLD   = 3'd3,
        ST_TURN   = 3'd4
    } state_e;

    localparam int DEF_ADDR_WIDTH    = 22;
    localparam int DEF_SETUP_CYCLES  = 1;
    localparam int DEF_STROBE_CYCLES = 2;
    localparam int DEF_HOLD_CYCLES   = 1;

    // Largest of three phase lengths; sizes the shared phase counter.
    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/usb_bus_master_if.sv
// Command, response and parallel-bus signals of the USB bus master, bundled in one interface.
// Latency: none, wiring only.
// Backpressure: cmd_ready is driven by the master; the slave side holds cmd_* until accepted.
interface usb_bus_master_if
    import usb_bus_pkg::*;
#(
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) ();

    logic                  cmd_valid;
    logic                  cmd_ready;
    logic                  cmd_write;
    logic [ADDR_WIDTH-1:0] cmd_addr;
    logic [7:0]            cmd_wdata;

    logic                  rsp_valid;
    logic [7:0]            rsp_rdata;

    logic [ADDR_WIDTH-1:0] usb_addr;
    logic [7:0]            usb_data_o;
    logic                  usb_data_oe;
    logic [7:0]            usb_data_i;
    logic                  usb_rd_n;
    logic                  usb_wr_n;
    logic                  usb_ce_n;

    logic                  busy;

    modport master (
        input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, usb_data_i,
        output cmd_ready, rsp_valid, rsp_rdata,
        output usb_addr, usb_data_o, usb_data_oe, usb_rd_n, usb_wr_n, usb_ce_n, busy
    );

    modport slave (
        output cmd_valid, cmd_write, cmd_addr, cmd_wdata, usb_data_i,
        input  cmd_ready, rsp_valid, rsp_rdata,
        input  usb_addr, usb_data_o, usb_data_oe, usb_rd_n, usb_wr_n, usb_ce_n, busy
    );

endinterface

// File: rtl/usb_bus_master.sv
// Purpose: turns single-byte read/write commands into CW305 parallel bus cycles (SETUP/STROBE/HOLD).
// Latency: SETUP+STROBE+HOLD cycles per transaction; read data pulses out SETUP+STROBE+1 cycles after accept.
// Backpressure: cmd_ready is high only in IDLE, one accept per transaction. Option macro: USB_BUS_MASTER_TURNAROUND_EN.
module usb_bus_master
    import usb_bus_pkg::*;
#(
    parameter int ADDR_WIDTH    = DEF_ADDR_WIDTH,
    parameter int SETUP_CYCLES  = DEF_SETUP_CYCLES,
    parameter int STROBE_CYCLES = DEF_STROBE_CYCLES,
    parameter int HOLD_CYCLES   = DEF_HOLD_CYCLES
) (
    input  logic             clk,
    input  logic             reset_n,
    usb_bus_master_if.master bus
);

    // Phase counter is loaded with length-1 on entry and the phase ends when it reads zero.
    localparam int CNT_W = $clog2(max3(SETUP_CYCLES, STROBE_CYCLES, HOLD_CYCLES) + 1);
    localparam logic [CNT_W-1:0] SETUP_LD  = CNT_W'(SETUP_CYCLES - 1);
    localparam logic [CNT_W-1:0] STROBE_LD = CNT_W'(STROBE_CYCLES - 1);
    localparam logic [CNT_W-1:0] HOLD_LD   = CNT_W'(HOLD_CYCLES - 1);

    state_e                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  accept;

    // Command fields latched at acceptance.
    logic                  wr_q, wr_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [7:0]            wdata_q, wdata_d;

    // Registered bus outputs, computed from the next state so pins never glitch.
    logic [ADDR_WIDTH-1:0] usb_addr_q, usb_addr_d;
    logic [7:0]            data_o_q, data_o_d;
    logic                  oe_q, oe_d;
    logic                  rd_n_q, rd_n_d;
    logic                  wr_n_q, wr_n_d;
    logic                  ce_n_q, ce_n_d;
    logic                  rsp_valid_q, rsp_valid_d;
    logic [7:0]            rsp_rdata_q, rsp_rdata_d;

`ifdef USB_BUS_MASTER_TURNAROUND_EN
    // High for the single IDLE cycle right after a read finished.
    logic                  rd_done_q, rd_done_d;
`endif

    // Next-state, phase counter and command latching.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        accept  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.cmd_valid) begin
                    accept  = 1'b1;
                    state_d = ST_SETUP;
                    cnt_d   = SETUP_LD;
`ifdef USB_BUS_MASTER_TURNAROUND_EN
                    if (bus.cmd_write && rd_done_q) begin
                        state_d = ST_TURN;
                        cnt_d   = '0;
                    end
`endif
                end
            end
            ST_TURN: begin
                state_d = ST_SETUP;
                cnt_d   = SETUP_LD;
            end
            ST_SETUP: begin
                if (cnt_q == '0) begin
                    state_d = ST_STROBE;
                    cnt_d   = STROBE_LD;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_STROBE: begin
                if (cnt_q == '0) begin
                    state_d = ST_HOLD;
                    cnt_d   = HOLD_LD;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_HOLD: begin
                if (cnt_q == '0) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase

        wr_d    = accept ? bus.cmd_write : wr_q;
        addr_d  = accept ? bus.cmd_addr  : addr_q;
        wdata_d = accept ? bus.cmd_wdata : wdata_q;
    end

    // Pin values for the upcoming state; address and write data persist into IDLE.
    always_comb begin
        ce_n_d      = 1'b1;
        rd_n_d      = 1'b1;
        wr_n_d      = 1'b1;
        oe_d        = 1'b0;
        usb_addr_d  = usb_addr_q;
        data_o_d    = data_o_q;
        if (state_d == ST_SETUP || state_d == ST_STROBE || state_d == ST_HOLD) begin
            ce_n_d     = 1'b0;
            usb_addr_d = addr_d;
            oe_d       = wr_d;
            if (wr_d) begin
                data_o_d = wdata_d;
            end
        end
        if (state_d == ST_STROBE) begin
            rd_n_d = wr_d;
            wr_n_d = ~wr_d;
        end
        // Read data is sampled on the edge that leaves STROBE, which is also HOLD entry.
        rsp_valid_d = (state_q == ST_STROBE) && (state_d == ST_HOLD) && !wr_q;
        rsp_rdata_d = rsp_valid_d ? bus.usb_data_i : rsp_rdata_q;
`ifdef USB_BUS_MASTER_TURNAROUND_EN
        rd_done_d   = (state_q == ST_HOLD) && (state_d == ST_IDLE) && !wr_q;
`endif
    end

    // FSM state, phase counter and latched command.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            wr_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            wr_q    <= wr_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
        end
    end

    // Output registers; reset drops strobes and chip enable immediately.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            usb_addr_q  <= '0;
            data_o_q    <= '0;
            oe_q        <= 1'b0;
            rd_n_q      <= 1'b1;
            wr_n_q      <= 1'b1;
            ce_n_q      <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
`ifdef USB_BUS_MASTER_TURNAROUND_EN
            rd_done_q   <= 1'b0;
`endif
        end else begin
            usb_addr_q  <= usb_addr_d;
            data_o_q    <= data_o_d;
            oe_q        <= oe_d;
            rd_n_q      <= rd_n_d;
            wr_n_q      <= wr_n_d;
            ce_n_q      <= ce_n_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
`ifdef USB_BUS_MASTER_TURNAROUND_EN
            rd_done_q   <= rd_done_d;
`endif
        end
    end

    assign bus.cmd_ready   = (state_q == ST_IDLE);
    assign bus.busy        = (state_q != ST_IDLE);
    assign bus.usb_addr    = usb_addr_q;
    assign bus.usb_data_o  = data_o_q;
    assign bus.usb_data_oe = oe_q;
    assign bus.usb_rd_n    = rd_n_q;
    assign bus.usb_wr_n    = wr_n_q;
    assign bus.usb_ce_n    = ce_n_q;
    assign bus.rsp_valid   = rsp_valid_q;
    assign bus.rsp_rdata   = rsp_rdata_q;

endmodule

// File: tb/tb_usb_bus_master.sv
// Bench for usb_bus_master: default-timing instance 0 and a 3/4/2-timing instance 1 against a target model.
// Latency: a transaction-level model predicts every pin per cycle from accept time and phase lengths.
// Backpressure: stimulus holds cmd_valid until the model/DUT shows cmd_ready.
module tb_usb_bus_master;

`ifdef USB_BUS_MASTER_TURNAROUND_EN
    localparam bit TURN_EN = 1'b1;
`else
    localparam bit TURN_EN = 1'b0;
`endif

    localparam int S_C[2] = '{1, 3};
    localparam int P_C[2] = '{2, 4};
    localparam int H_C[2] = '{1, 2};

    logic clk;
    logic rst_n;

    logic [1:0]  cmd_valid, cmd_write;
    logic [21:0] cmd_addr  [2];
    logic [7:0]  cmd_wdata [2];
    logic [7:0]  data_i    [2];

    logic [1:0]  o_ready, o_rv, o_oe, o_rd_n, o_wr_n, o_ce_n, o_busy;
    logic [21:0] o_addr  [2];
    logic [7:0]  o_do    [2];
    logic [7:0]  o_rdata [2];

    logic [7:0]  mem_out [256];
    logic [7:0]  mem_in0 [256];

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;
    int cyc      = 0;

    // Transaction-level model state per instance.
    bit          m_act      [2];
    bit          m_wr       [2];
    bit          m_prev_rd  [2];
    bit          m_ready_b  [2];
    int          m_a        [2];
    int          m_len      [2];
    int          m_turn     [2];
    int          m_prev_end [2];
    logic [21:0] m_addr     [2];
    logic [21:0] m_last_addr[2];
    logic [7:0]  m_wdata    [2];
    logic [7:0]  m_rdata    [2];

    logic        e_ce, e_rd, e_wr, e_oe, e_rv, e_rdy, e_busy, e_chk_do;
    logic [21:0] e_addr;
    logic [7:0]  e_do;
    int          k, j;

    usb_bus_master_if #(.ADDR_WIDTH(22)) bus0 ();
    usb_bus_master_if #(.ADDR_WIDTH(22)) bus1 ();

    usb_bus_master #(.ADDR_WIDTH(22)) dut0 (
        .clk(clk), .reset_n(rst_n), .bus(bus0.master)
    );
    usb_bus_master #(.ADDR_WIDTH(22), .SETUP_CYCLES(3), .STROBE_CYCLES(4), .HOLD_CYCLES(2)) dut1 (
        .clk(clk), .reset_n(rst_n), .bus(bus1.master)
    );

    assign bus0.cmd_valid = cmd_valid[0];
    assign bus0.cmd_write = cmd_write[0];
    assign bus0.cmd_addr  = cmd_addr[0];
    assign bus0.cmd_wdata = cmd_wdata[0];
    assign bus0.usb_data_i = data_i[0];
    assign bus1.cmd_valid = cmd_valid[1];
    assign bus1.cmd_write = cmd_write[1];
    assign bus1.cmd_addr  = cmd_addr[1];
    assign bus1.cmd_wdata = cmd_wdata[1];
    assign bus1.usb_data_i = data_i[1];

    assign o_ready = {bus1.cmd_ready,   bus0.cmd_ready};
    assign o_rv    = {bus1.rsp_valid,   bus0.rsp_valid};
    assign o_oe    = {bus1.usb_data_oe, bus0.usb_data_oe};
    assign o_rd_n  = {bus1.usb_rd_n,    bus0.usb_rd_n};
    assign o_wr_n  = {bus1.usb_wr_n,    bus0.usb_wr_n};
    assign o_ce_n  = {bus1.usb_ce_n,    bus0.usb_ce_n};
    assign o_busy  = {bus1.busy,        bus0.busy};
    assign o_addr[0]  = bus0.usb_addr;
    assign o_addr[1]  = bus1.usb_addr;
    assign o_do[0]    = bus0.usb_data_o;
    assign o_do[1]    = bus1.usb_data_o;
    assign o_rdata[0] = bus0.rsp_rdata;
    assign o_rdata[1] = bus1.rsp_rdata;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Target side: registered read data, write capture on strobe low.
    always @(posedge clk) begin
        data_i[0] <= mem_out[o_addr[0][7:0]];
        data_i[1] <= mem_out[o_addr[1][7:0]];
        if (!o_wr_n[0]) mem_in0[o_addr[0][7:0]] <= o_do[0];
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %0h required %0h (cycle %0d)", nm, act, exp, cyc);
        end else begin
            n_pass++;
        end
    endtask

    // Model: track accepts and transaction lifetimes at each clock edge.
    always @(posedge clk) begin
        cyc++;
        for (int i = 0; i < 2; i++) begin
            if (!rst_n) begin
                m_act[i]       = 1'b0;
                m_last_addr[i] = '0;
                m_rdata[i]     = '0;
                m_prev_end[i]  = -100;
                m_prev_rd[i]   = 1'b0;
            end else begin
                m_ready_b[i] = !m_act[i];
                if (m_act[i] && cyc >= m_a[i] + m_len[i]) begin
                    m_act[i]       = 1'b0;
                    m_prev_end[i]  = cyc;
                    m_prev_rd[i]   = !m_wr[i];
                    m_last_addr[i] = m_addr[i];
                end
                if (m_ready_b[i] && cmd_valid[i]) begin
                    m_act[i]   = 1'b1;
                    m_a[i]     = cyc;
                    m_wr[i]    = cmd_write[i];
                    m_addr[i]  = cmd_addr[i];
                    m_wdata[i] = cmd_wdata[i];
                    m_turn[i]  = (TURN_EN && cmd_write[i] && m_prev_rd[i] && cyc == m_prev_end[i] + 1) ? 1 : 0;
                    m_len[i]   = m_turn[i] + S_C[i] + P_C[i] + H_C[i];
                end
            end
        end
    end

    // Compare every pin of both instances mid-cycle against the model.
    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            e_ce = 1'b1; e_rd = 1'b1; e_wr = 1'b1; e_oe = 1'b0; e_rv = 1'b0;
            e_chk_do = 1'b0; e_do = '0;
            if (!rst_n) begin
                e_addr = '0; e_rdy = 1'b1; e_busy = 1'b0; e_chk_do = 1'b1;
                m_rdata[i] = '0;
            end else begin
                e_addr = m_last_addr[i];
                e_rdy  = !m_act[i];
                e_busy = m_act[i];
                if (m_act[i]) begin
                    k = cyc - m_a[i] + 1;
                    j = k - m_turn[i];
                    if (j >= 1) begin
                        e_ce = 1'b0; e_addr = m_addr[i]; e_oe = m_wr[i];
                        e_chk_do = m_wr[i]; e_do = m_wdata[i];
                    end
                    if (j > S_C[i] && j <= S_C[i] + P_C[i]) begin
                        e_rd = m_wr[i]; e_wr = !m_wr[i];
                    end
                    if (j == S_C[i] + P_C[i] + 1 && !m_wr[i]) begin
                        e_rv = 1'b1;
                        m_rdata[i] = mem_out[m_addr[i][7:0]];
                    end
                end
            end
            chk($sformatf("ce_n%0d", i),  32'(o_ce_n[i]),  32'(e_ce));
            chk($sformatf("rd_n%0d", i),  32'(o_rd_n[i]),  32'(e_rd));
            chk($sformatf("wr_n%0d", i),  32'(o_wr_n[i]),  32'(e_wr));
            chk($sformatf("oe%0d", i),    32'(o_oe[i]),    32'(e_oe));
            chk($sformatf("addr%0d", i),  32'(o_addr[i]),  32'(e_addr));
            chk($sformatf("rspv%0d", i),  32'(o_rv[i]),    32'(e_rv));
            chk($sformatf("rdata%0d", i), 32'(o_rdata[i]), 32'(m_rdata[i]));
            chk($sformatf("ready%0d", i), 32'(o_ready[i]), 32'(e_rdy));
            chk($sformatf("busy%0d", i),  32'(o_busy[i]),  32'(e_busy));
            if (e_chk_do) chk($sformatf("wdat%0d", i), 32'(o_do[i]), 32'(e_do));
        end
    end

    // Present a command and wait (bounded) for it to be taken; returns the accept edge.
    task automatic issue(input int i, input bit wr, input logic [21:0] a, input logic [7:0] d,
                         output int acc_edge);
        int n;
        bit got;
        cmd_write[i] = wr; cmd_addr[i] = a; cmd_wdata[i] = d; cmd_valid[i] = 1'b1;
        n = 0; got = 1'b0;
        while (!got && n < 50) begin
            @(negedge clk);
            got = o_ready[i];
            n++;
        end
        chk($sformatf("accept%0d", i), 32'(got), 32'd1);
        @(posedge clk);
        #2;
        acc_edge = cyc;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: actual timeout required finish");
        $fatal(1);
    end

    initial begin
        int e1, e2, e3, c_wr, c_oe, c_nr, c_rv, at_k, c_st;
        logic [7:0] rd;
        rst_n = 1'b0;
        cmd_valid = '0; cmd_write = '0;
        for (int i = 0; i < 2; i++) begin cmd_addr[i] = '0; cmd_wdata[i] = '0; end
        for (int i = 0; i < 256; i++) mem_out[i] = 8'($urandom);
        mem_out[8'h12] = 8'h3C;

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_ce_n",   32'(o_ce_n[0]), 32'd1);
        chk("rst_rd_wr",  32'({o_rd_n[0], o_wr_n[0]}), 32'd3);
        chk("rst_oe",     32'(o_oe[0]), 32'd0);
        chk("rst_addr",   32'(o_addr[0]), 32'd0);
        chk("rst_dato",   32'(o_do[0]), 32'd0);
        chk("rst_rdata",  32'(o_rdata[0]), 32'd0);
        @(posedge clk); #2;
        rst_n = 1'b1;

        // Write 0xA5 to 0x000105.
        issue(0, 1'b1, 22'h000105, 8'hA5, e1);
        cmd_valid[0] = 1'b0;
        c_wr = 0; c_oe = 0; c_nr = 0;
        for (int n = 1; n <= 5; n++) begin
            @(negedge clk);
            c_wr += int'(!o_wr_n[0]); c_oe += int'(o_oe[0]); c_nr += int'(!o_ready[0]);
        end
        chk("wr_low_cycles",   32'(c_wr), 32'd2);
        chk("oe_cycles",       32'(c_oe), 32'd4);
        chk("ready_low_cyc",   32'(c_nr), 32'd4);
        chk("target_byte5",    32'(mem_in0[8'h05]), 32'hA5);

        // Read 0x000012, target returns 0x3C.
        issue(0, 1'b0, 22'h000012, 8'h00, e1);
        cmd_valid[0] = 1'b0;
        c_rv = 0; at_k = 0; c_oe = 0; rd = '0;
        for (int n = 1; n <= 5; n++) begin
            @(negedge clk);
            if (o_rv[0]) begin c_rv++; at_k = n; rd = o_rdata[0]; end
            c_oe += int'(o_oe[0]);
        end
        chk("rsp_pulses",  32'(c_rv), 32'd1);
        chk("rsp_latency", 32'(at_k), 32'd4);
        chk("rsp_data",    32'(rd),   32'h3C);
        chk("rd_oe_cyc",   32'(c_oe), 32'd0);

        // Back-to-back write/read/write with valid held high.
        issue(0, 1'b1, 22'h0000AA, 8'h11, e1);
        issue(0, 1'b0, 22'h000012, 8'h00, e2);
        issue(0, 1'b1, 22'h0000BB, 8'h22, e3);
        cmd_valid[0] = 1'b0;
        chk("gap_wr_rd", 32'(e2 - e1), 32'd5);
        chk("gap_rd_wr", 32'(e3 - e2), TURN_EN ? 32'd6 : 32'd5);
        repeat (8) @(negedge clk);

        // Reset in the middle of a read strobe.
        issue(0, 1'b0, 22'h000012, 8'h00, e1);
        cmd_valid[0] = 1'b0;
        @(posedge clk); #2;
        chk("strobe_rd_n", 32'(o_rd_n[0]), 32'd0);
        #1 rst_n = 1'b0;
        #1;
        chk("arst_rd_n", 32'(o_rd_n[0]), 32'd1);
        chk("arst_ce_n", 32'(o_ce_n[0]), 32'd1);
        @(posedge clk);
        @(posedge clk); #2;
        rst_n = 1'b1;
        c_rv = 0;
        for (int n = 1; n <= 6; n++) begin
            @(negedge clk);
            if (n == 1) chk("post_rst_ready", 32'(o_ready[0]), 32'd1);
            c_rv += int'(o_rv[0]);
        end
        chk("post_rst_no_rsp", 32'(c_rv), 32'd0);

        // Long timing instance: write 0xFF to all-ones address.
        issue(1, 1'b1, 22'h3FFFFF, 8'hFF, e1);
        cmd_valid[1] = 1'b0;
        c_st = 0; c_wr = 0;
        for (int n = 1; n <= 11; n++) begin
            @(negedge clk);
            if (!o_ce_n[1] && o_addr[1] == 22'h3FFFFF) c_st++;
            c_wr += int'(!o_wr_n[1]);
        end
        chk("long_addr_stable", 32'(c_st), 32'd9);
        chk("long_wr_low",      32'(c_wr), 32'd4);

        // Random traffic on both instances; fields change every cycle.
        repeat (600) begin
            @(posedge clk); #2;
            for (int i = 0; i < 2; i++) begin
                cmd_valid[i] = ($urandom_range(0, 3) != 0);
                cmd_write[i] = 1'($urandom_range(0, 1));
                cmd_addr[i]  = ($urandom_range(0, 7) == 0) ? 22'h3FFFFF : 22'($urandom);
                cmd_wdata[i] = 8'($urandom);
            end
        end
        @(posedge clk); #2;
        cmd_valid = '0;
        repeat (15) @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
